// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared widths, FSM state type and quarter-wave table builder
// Contents: default parameter values, tone_state_t, quarter_sine_entry().
package tone_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int LUT_AW_DEF  = 6;
    localparam int OUT_W_DEF   = 8;
    localparam int CNT_W_DEF   = 16;

    localparam real TONE_PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tone_state_t;

    // Entry i of the first quadrant, sampled at the half-step (i+0.5) so the
    // four quadrants mirror onto each other exactly and no entry is zero.
    // Taylor series keeps this usable as an elaboration-time constant.
    function automatic int quarter_sine_entry(input int i, input int out_w, input int lut_aw);
        real x;
        real term;
        real sum;
        real amp;
        x    = 2.0 * TONE_PI * (real'(i) + 0.5) / real'(2 ** (lut_aw + 2));
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = real'((2 ** (out_w - 1)) - 1);
        return $rtoi(amp * sum + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// rtl/sine_quarter_lut.sv - registered quadrant fold, quarter-wave table, negate and attenuate
// Ports: clk, rst (async, active-high); phase = top LUT_AW+2 phase bits;
//        phase_valid qualifies phase; atten = arithmetic right shift;
//        sample = registered signed result, zero when phase_valid was low.
module sine_quarter_lut
    import tone_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LUT_AW+1:0]       phase,
    input  logic                    phase_valid,
    input  logic [2:0]              atten,
    output logic signed [OUT_W-1:0] sample
);

    localparam int DEPTH = 2 ** LUT_AW;

    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam int ENTRY = quarter_sine_entry(g, OUT_W, LUT_AW);
        assign rom[g] = ENTRY[OUT_W-2:0];
    end

    logic [1:0]              quad;
    logic [LUT_AW-1:0]       idx;
    logic [OUT_W-2:0]        mag;
    logic signed [OUT_W-1:0] val;
    logic signed [OUT_W-1:0] shifted;

    always_comb begin
        quad = phase[LUT_AW+1:LUT_AW];
        idx  = phase[LUT_AW-1:0];
        // Odd quadrants run the table backwards; upper half-cycle is negative.
        if (quad[0]) begin
            idx = ~idx;
        end
        mag     = rom[idx];
        val     = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        shifted = val >>> atten;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample <= '0;
        end else begin
            sample <= phase_valid ? shifted : '0;
        end
    end

endmodule

// File: rtl/tone_burst_tx.sv
// rtl/tone_burst_tx.sv - gated NCO sine burst transmitter with start/busy/done handshake
// Ports: clk, rst (async, active-high); start/ftw/cycles/atten request a burst;
//        busy/done handshake; sample/sample_valid stream; wrap marks the
//        sample whose phase increment carries out.
module tone_burst_tx
    import tone_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PHASE_W-1:0]      ftw,
    input  logic [CNT_W-1:0]        cycles,
    input  logic [2:0]              atten,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] sample,
    output logic                    sample_valid,
    output logic                    wrap
);

    tone_state_t state;
    tone_state_t state_nx;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] ftw_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   cycles_q;
    logic [2:0]         atten_q;
    logic               reject_q;

    // Pipeline stage feeding the table, then the stage aligned with the sample.
    logic [LUT_AW+1:0]  lut_phase;
    logic               lut_phase_valid;
    logic               lut_wrap;
    logic               out_valid;
    logic               out_wrap;

    logic [PHASE_W:0]   phase_sum;
    logic               carry;
    logic               accept;
    logic               zero_req;
    logic               last_step;
    logic               flushed;

    always_comb begin
        phase_sum = {1'b0, phase} + {1'b0, ftw_q};
        carry     = phase_sum[PHASE_W];
        cnt_inc   = cnt + CNT_W'(1);
        // A rejected request is answered with done; that cycle does not accept.
        accept    = (state == IDLE) && start && !reject_q;
        zero_req  = (cycles == '0) || (ftw == '0);
        last_step = carry && (cnt_inc == cycles_q);
        flushed   = !lut_phase_valid && !out_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DRAIN holds until both pipeline stages are empty, so done lands in the
    // cycle right after the last sample while the FSM is still out of IDLE.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = reject_q;
        case (state)
            IDLE: begin
                if (accept && !zero_req) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (flushed) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase           <= '0;
            ftw_q           <= '0;
            cnt             <= '0;
            cycles_q        <= '0;
            atten_q         <= '0;
            reject_q        <= 1'b0;
            lut_phase       <= '0;
            lut_phase_valid <= 1'b0;
            lut_wrap        <= 1'b0;
            out_valid       <= 1'b0;
            out_wrap        <= 1'b0;
        end else begin
            reject_q        <= accept && zero_req;
            lut_phase_valid <= 1'b0;
            lut_wrap        <= 1'b0;
            if (accept) begin
                ftw_q    <= ftw;
                cycles_q <= cycles;
                atten_q  <= atten;
                phase    <= '0;
                cnt      <= '0;
            end else if (state == RUN) begin
                lut_phase       <= phase[PHASE_W-1 -: LUT_AW+2];
                lut_phase_valid <= 1'b1;
                lut_wrap        <= carry;
                phase           <= phase_sum[PHASE_W-1:0];
                if (carry) begin
                    cnt <= cnt_inc;
                end
            end
            out_valid <= lut_phase_valid;
            out_wrap  <= lut_wrap;
        end
    end

    sine_quarter_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk         (clk),
        .rst         (rst),
        .phase       (lut_phase),
        .phase_valid (lut_phase_valid),
        .atten       (atten_q),
        .sample      (sample)
    );

    assign sample_valid = out_valid;
    assign wrap         = out_wrap;

endmodule
